mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported RAM between instruction fetch (I) and data access (D) requesters.
//  Data has priority; a bounded-starvation counter guarantees fetch progress.
//  Implements the LL/SC link register consumed by the LinkedLoad/StoreConditional control signals.
//  Sits between the I/D request ports of the datapath and the RAM model.
// PARAMETERS
//  STARVE_MAX  4   consecutive D grants allowed while iREN pending before I is forced (>=1)
// PORTS
//  CLK        in   1   clock, rising edge; the only clock
//  nRST       in   1   reset, synchronous, active-low
//  iREN       in   1   instruction read request
//  iaddr      in   32  instruction address
//  iwait      out  1   1 = I request not yet complete
//  iload      out  32  instruction data, valid when iREN & ~iwait
//  dREN       in   1   data read request (LL when datomic)
//  dWEN       in   1   data write request (SC when datomic); never asserted with dREN
//  datomic    in   1   qualifies dREN as LL, dWEN as SC
//  daddr      in   32  data address (word aligned)
//  dstore     in   32  write data
//  dwait      out  1   1 = D request not yet complete
//  dload      out  32  read data; for SC: 1 = success, 0 = fail
//  ramREN     out  1   RAM read enable
//  ramWEN     out  1   RAM write enable
//  ramaddr    out  32  RAM address
//  ramstore   out  32  RAM write data
//  ramload    in   32  RAM read data
//  ramstate   in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
//  memerr     out  1   sticky; set on ERROR completion, cleared only by reset
// BEHAVIOUR
//  FSM states IDLE, DACC, IACC (registered). Reset (nRST=0 at edge): state IDLE, link invalid,
//   starve count 0, memerr 0. While in IDLE: ramREN=ramWEN=0.
//  Wait outputs are combinational: iwait = iREN & ~idone; dwait = (dREN|dWEN) & ~ddone.
//  IDLE arbitration:
//   D pending and cnt<STARVE_MAX, or no iREN -> DACC.
//   Otherwise iREN -> IACC.
//   Else stay.
//  SC whose link is invalid or whose address != link address: no RAM access, stay IDLE.
//   ddone=1 that cycle, dload=0, link cleared. Not counted as a D grant.
//  DACC: ramaddr=daddr, ramREN=dREN, ramWEN=dWEN, ramstore=dstore.
//   Hold until ramstate==ACCESS or ERROR, then ddone=1, dload=ramload (SC: dload=1), -> IDLE.
//  IACC: ramaddr=iaddr, ramREN=1. On ACCESS/ERROR: idone=1, iload=ramload, -> IDLE.
//  Latency: 1 IDLE cycle + RAM cycles.
//   FREE/BUSY = wait.
//   ACCESS in first DACC/IACC cycle -> done 2 cycles after request.
//   Bubble IDLE cycle after every completion.
//  ERROR completes like ACCESS (load data = ramload, SC reports 1 if the write was attempted)
//   and sets memerr.
//  Starve counter: increment on each D grant while iREN=1 (saturates at STARVE_MAX);
//   reset to 0 on I grant or when iREN=0 in IDLE.
//  Link register {valid, addr[31:0]}:
//   LL completion sets valid and addr=daddr.
//   SC completion (pass or fail) clears valid.
//   Plain SW completion with daddr==addr clears valid.
//   Simultaneous set and clear is impossible (one D access per completion).
//  Requester drops its request mid-access: the access still completes on the RAM;
//   the result is discarded and the FSM returns to IDLE.
//  Reset mid-access: abort immediately; RAM enables drop the next cycle; no link update.
// STRUCTURE
//  cpu_types_pkg: ramstate_t (FREE/BUSY/ACCESS/ERROR), word_t, arb_state_t {IDLE,DACC,IACC}.
//  One sub-module: link_reg (valid/addr register with set/clear/match); FSM and mux stay inline.
// TESTING
//  1 iREN only, ramstate ACCESS on 1st IACC cycle -> iwait low in cycle 2, iload=ramload, ramREN=1 in IACC.
//  2 dREN+iREN together, RAM 1-cycle -> D served first, I served next (IDLE bubble between); ramaddr sequence daddr, iaddr.
//  3 dWEN held 6 requests back-to-back with iREN=1, STARVE_MAX=4 -> 4 D grants, then an I grant, counter back to 0.
//  4 LL 0x40 -> SC 0x40 data 0xDEAD -> ramWEN=1, dload=1. Second SC 0x40 -> no ramWEN, dload=0 in 1 cycle.
//  5 LL 0x80, SW 0x80, SC 0x80 -> SC fails (dload=0, ramWEN never asserted); with LL 0x80, SW 0x84, SC 0x80 -> SC passes.
//  6 nRST low during DACC with ramstate BUSY -> next cycle IDLE, ram enables 0, link invalid; ERROR completion -> memerr=1 until reset.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the memory-side glue of the CPU: the RAM handshake state,
//   the machine word, the arbiter FSM states and the latched RAM request.
//   ram_done() tells whether a RAM handshake state ends the current access.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM handshake as reported by the RAM model.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM: IDLE arbitrates, DACC/IACC own the RAM for one access.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } arb_state_t;

  // Request captured at grant time. The RAM is driven from this copy, so an
  // access runs to completion even if the requester changes its inputs.
  typedef struct packed {
    logic  ren;
    logic  wen;
    logic  atomic;
    word_t addr;
    word_t store;
  } ram_req_t;

  // ERROR terminates an access exactly like ACCESS does.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter_link_reg.sv
// -----------------------------------------------------------------------------
// link_reg
//   LL/SC link register {valid, addr}.
//   Ports:
//     CLK, nRST     clock / synchronous active-low reset (clears valid)
//     set           load the link with set_addr and mark it valid
//     set_addr      address recorded by a completing LL
//     clr           unconditional invalidate (SC completion, pass or fail)
//     clr_on_match  invalidate only when clr_addr equals the linked address
//     clr_addr      address of a completing plain store
//     chk_addr      address an SC wants to use
//     chk_match     link valid and chk_addr equals the linked address
// -----------------------------------------------------------------------------
module link_reg
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        set,
  input  logic [31:0] set_addr,
  input  logic        clr,
  input  logic        clr_on_match,
  input  logic [31:0] clr_addr,
  input  logic [31:0] chk_addr,
  output logic        chk_match
);

  logic  valid_reg;
  word_t addr_reg;

  // Set and clear come from different completions, so they never coincide;
  // set is given precedence only to keep the logic unambiguous.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
    end else if (set) begin
      valid_reg <= 1'b1;
      addr_reg  <= set_addr;
    end else if (clr || (clr_on_match && (clr_addr == addr_reg))) begin
      valid_reg <= 1'b0;
    end
  end

  assign chk_match = valid_reg && (chk_addr == addr_reg);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported RAM between instruction fetch (I) and data (D).
//   D has priority, but after STARVE_MAX consecutive D grants with a fetch
//   pending the fetch is forced through. Also hosts the LL/SC link register.
//   Ports:
//     CLK, nRST                clock / synchronous active-low reset
//     iREN, iaddr              instruction read request and address
//     iwait, iload             fetch not yet done / fetched word
//     dREN, dWEN, datomic      data read / write request; datomic makes them LL / SC
//     daddr, dstore            data address / write data
//     dwait, dload             data not yet done / read data (SC: 1 pass, 0 fail)
//     ramREN, ramWEN           RAM read / write enables (registered)
//     ramaddr, ramstore        RAM address / write data (registered)
//     ramload, ramstate        RAM read data / handshake state
//     memerr                   sticky: an access finished with ERROR
//   Parameter:
//     STARVE_MAX               consecutive D grants tolerated while I waits (>=1)
// -----------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Registered state
  arb_state_t       state_reg;
  ram_req_t         req_reg;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic             memerr_reg;

  // Decode
  ramstate_t ram_st;
  logic      ram_ok;
  logic      d_pend;
  logic      link_match;
  logic      sc_reject;
  logic      starved;
  logic      d_grant;
  logic      i_grant;
  logic      d_complete;
  logic      i_complete;
  logic      ddone;
  logic      idone;
  logic      link_set;
  logic      link_clr;
  logic      sw_complete;

  assign ram_st = ramstate_t'(ramstate);
  assign ram_ok = ram_done(ram_st);
  assign d_pend = dREN | dWEN;

  // An SC without a matching link is answered from IDLE without touching the
  // RAM; it does not count as a D grant and blocks any grant that cycle.
  assign sc_reject = (state_reg == IDLE) && dWEN && datomic && !link_match;

  assign starved = (starve_cnt_reg >= CNT_MAX);
  assign d_grant = (state_reg == IDLE) && d_pend && !sc_reject && (!starved || !iREN);
  assign i_grant = (state_reg == IDLE) && iREN && !sc_reject && !d_grant;

  assign d_complete = (state_reg == DACC) && ram_ok;
  assign i_complete = (state_reg == IACC) && ram_ok;

  assign ddone = d_complete | sc_reject;
  assign idone = i_complete;

  // Requester-facing outputs are combinational so completion is seen in the
  // same cycle the RAM reports it.
  assign iwait = iREN & ~idone;
  assign dwait = d_pend & ~ddone;
  assign iload = ramload;

  always_comb begin
    dload = ramload;
    if (sc_reject) begin
      dload = 32'd0;
    end else if (d_complete && req_reg.atomic && req_reg.wen) begin
      dload = 32'd1;
    end
  end

  // Link updates use the latched request so they follow what the RAM did.
  assign sw_complete = d_complete && req_reg.wen && !req_reg.atomic;
  assign link_set    = d_complete && req_reg.ren && req_reg.atomic;
  assign link_clr    = sc_reject || (d_complete && req_reg.wen && req_reg.atomic);

  link_reg u_link_reg (
    .CLK          (CLK),
    .nRST         (nRST),
    .set          (link_set),
    .set_addr     (req_reg.addr),
    .clr          (link_clr),
    .clr_on_match (sw_complete),
    .clr_addr     (req_reg.addr),
    .chk_addr     (daddr),
    .chk_match    (link_match)
  );

  // RAM side is driven straight from the latched request; the enables are
  // cleared on completion, so they are always low in IDLE.
  assign ramREN   = req_reg.ren;
  assign ramWEN   = req_reg.wen;
  assign ramaddr  = req_reg.addr;
  assign ramstore = req_reg.store;
  assign memerr   = memerr_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      req_reg        <= '0;
      starve_cnt_reg <= '0;
      memerr_reg     <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (d_grant) begin
            state_reg      <= DACC;
            req_reg.ren    <= dREN;
            req_reg.wen    <= dWEN;
            req_reg.atomic <= datomic;
            req_reg.addr   <= daddr;
            req_reg.store  <= dstore;
          end else if (i_grant) begin
            state_reg      <= IACC;
            req_reg.ren    <= 1'b1;
            req_reg.wen    <= 1'b0;
            req_reg.atomic <= 1'b0;
            req_reg.addr   <= iaddr;
          end

          // Count D grants that overtake a waiting fetch; saturating.
          if (!iREN || i_grant) begin
            starve_cnt_reg <= '0;
          end else if (d_grant && !starved) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end
        end

        DACC, IACC: begin
          // Always return through IDLE, giving one bubble cycle per access.
          if (ram_ok) begin
            state_reg   <= IDLE;
            req_reg.ren <= 1'b0;
            req_reg.wen <= 1'b0;
          end
        end

        default: begin
          state_reg   <= IDLE;
          req_reg.ren <= 1'b0;
          req_reg.wen <= 1'b0;
        end
      endcase

      if ((d_complete || i_complete) && (ram_st == ERROR)) begin
        memerr_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Bench for mem_arbiter: a RAM model with configurable latency/error, a
//   transaction-level reference (word memory + link + sticky error + starvation
//   streak) checked every cycle, and directed scenarios with literal values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic        datomic;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  int checks = 0;
  int errors = 0;

  int   ram_lat     = 0;
  logic force_error = 1'b0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .datomic  (datomic),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .memerr   (memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Power-up / reset content of every word: 0xC0DE in the top half, the byte
  // address in the bottom half.
  function automatic logic [31:0] init_word(input int i);
    logic [7:0] idx;
    idx = i[7:0];
    return {16'hC0DE, 6'b0, idx, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:255];
  int          busy_cnt;

  always_comb begin
    ramstate = 2'd0;
    if (ramREN || ramWEN) begin
      if (busy_cnt >= ram_lat) ramstate = force_error ? 2'd3 : 2'd2;
      else                     ramstate = 2'd1;
    end
  end

  assign ramload = mem[ramaddr[9:2]];

  always @(posedge CLK) begin
    if (!nRST) begin
      busy_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (ramREN || ramWEN) begin
      if (ramstate[1]) begin
        busy_cnt <= 0;
        if (ramWEN) mem[ramaddr[9:2]] <= ramstore;
      end else begin
        busy_cnt <= busy_cnt + 1;
      end
    end else begin
      busy_cnt <= 0;
    end
  end

  // ---------------- Reference model and per-cycle compare ----------------
  logic [31:0] ref_mem [0:255];
  logic        link_v_m;
  logic [31:0] link_a_m;
  logic        memerr_m;
  int          streak;

  initial begin : compare
    logic ok;
    logic sc_ok;
    link_v_m = 1'b0;
    link_a_m = '0;
    memerr_m = 1'b0;
    streak   = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        link_v_m = 1'b0;
        memerr_m = 1'b0;
        streak   = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      end else begin
        check("memerr", 32'(memerr), 32'(memerr_m));

        if (ramREN) begin
          ok = !ramWEN && ((dREN && ramaddr == daddr) || (iREN && ramaddr == iaddr));
          check("ram_read_legal", 32'(ok), 32'd1);
        end
        if (ramWEN) begin
          ok = dWEN && (ramaddr == daddr) && (ramstore == dstore) &&
               (!datomic || (link_v_m && link_a_m == daddr));
          check("ram_write_legal", 32'(ok), 32'd1);
        end

        if ((dREN || dWEN) && !dwait) begin
          if (dWEN && datomic) begin
            sc_ok = link_v_m && (link_a_m == daddr);
            check("sc_result", dload, 32'(sc_ok));
            if (sc_ok) ref_mem[daddr[9:2]] = dstore;
            link_v_m = 1'b0;
          end else if (dWEN) begin
            ref_mem[daddr[9:2]] = dstore;
            if (link_v_m && link_a_m == daddr) link_v_m = 1'b0;
            sc_ok = 1'b1;
          end else begin
            check("d_load", dload, ref_mem[daddr[9:2]]);
            if (datomic) begin
              link_v_m = 1'b1;
              link_a_m = daddr;
            end
            sc_ok = 1'b1;
          end
          // sc_ok here means "this completion used the RAM"
          if (sc_ok) begin
            if (ramstate == 2'd3) memerr_m = 1'b1;
            if (iREN) begin
              streak++;
              check("starve_bound", 32'(streak <= STARVE_MAX), 32'd1);
            end
          end
        end

        if (iREN && !iwait) begin
          check("i_load", iload, ref_mem[iaddr[9:2]]);
          if (ramstate == 2'd3) memerr_m = 1'b1;
          streak = 0;
        end
        if (!iREN) streak = 0;
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic d_txn(input logic ren, input logic wen, input logic at,
                       input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output logic [31:0] ld, output logic saw_wen);
    @(posedge CLK); #1;
    dREN = ren; dWEN = wen; datomic = at; daddr = a; dstore = d;
    cyc = 0; saw_wen = 1'b0;
    do begin
      @(negedge CLK);
      cyc++;
      if (ramWEN) saw_wen = 1'b1;
    end while (dwait && cyc < 200);
    check("d_timeout", 32'(dwait), 32'd0);
    ld = dload;
    @(posedge CLK); #1;
    dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          cyc;
    logic [31:0] ld;
    logic        sw;
    int          nd;
    int          ni;
    string       order;
    logic        d_hit;
    logic        i_hit;

    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    datomic = 1'b0; daddr = '0; dstore = '0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset state
    @(negedge CLK);
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_memerr", 32'(memerr), 32'd0);
    check("rst_iwait", 32'(iwait), 32'd0);
    check("rst_dwait", 32'(dwait), 32'd0);

    // 1: fetch only, RAM answers in the first IACC cycle
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h100;
    @(negedge CLK);
    check("t1_iwait_c1", 32'(iwait), 32'd1);
    check("t1_ramREN_c1", 32'(ramREN), 32'd0);
    @(negedge CLK);
    check("t1_iwait_c2", 32'(iwait), 32'd0);
    check("t1_iload", iload, 32'hC0DE0100);
    check("t1_ramREN_c2", 32'(ramREN), 32'd1);
    check("t1_ramaddr", ramaddr, 32'h100);
    @(posedge CLK); #1;
    iREN = 1'b0;

    // 2: D and I together: D first, bubble, then I
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h104; dREN = 1'b1; daddr = 32'h200;
    @(negedge CLK);
    check("t2_c1_ramREN", 32'(ramREN), 32'd0);
    @(negedge CLK);
    check("t2_c2_ramaddr", ramaddr, 32'h200);
    check("t2_c2_dwait", 32'(dwait), 32'd0);
    check("t2_c2_dload", dload, 32'hC0DE0200);
    check("t2_c2_iwait", 32'(iwait), 32'd1);
    @(posedge CLK); #1;
    dREN = 1'b0;
    @(negedge CLK);
    check("t2_c3_bubble", 32'(ramREN), 32'd0);
    check("t2_c3_iwait", 32'(iwait), 32'd1);
    @(negedge CLK);
    check("t2_c4_ramaddr", ramaddr, 32'h104);
    check("t2_c4_iwait", 32'(iwait), 32'd0);
    check("t2_c4_iload", iload, 32'hC0DE0104);
    @(posedge CLK); #1;
    iREN = 1'b0;

    // 3: six back-to-back stores against a pending fetch
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h120; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h5000;
    nd = 0; ni = 0; order = ""; cyc = 0;
    while ((nd < 6 || ni < 2) && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      d_hit = dWEN && !dwait;
      i_hit = iREN && !iwait;
      if (d_hit) order = {order, "D"};
      if (i_hit) order = {order, "I"};
      @(posedge CLK); #1;
      if (d_hit) begin
        nd++;
        if (nd == 6) dWEN = 1'b0;
        else begin
          daddr  = 32'h300 + 32'(nd * 4);
          dstore = 32'h5000 + 32'(nd);
        end
      end
      if (i_hit) begin
        ni++;
        if (ni == 2) iREN = 1'b0;
        else         iaddr = 32'h124;
      end
    end
    checks++;
    if (order != "DDDDIDDI") begin
      errors++;
      $display("FAIL t3_order: got %s, expected DDDDIDDI", order);
    end
    dWEN = 1'b0; iREN = 1'b0;

    // 4: LL / SC pass / SC repeat fails
    d_txn(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, cyc, ld, sw);
    check("t4_ll_data", ld, 32'hC0DE0040);
    d_txn(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEAD, cyc, ld, sw);
    check("t4_sc1_dload", ld, 32'd1);
    check("t4_sc1_wen", 32'(sw), 32'd1);
    check("t4_sc1_cycles", 32'(cyc), 32'd2);
    d_txn(1'b0, 1'b1, 1'b1, 32'h40, 32'hBEEF, cyc, ld, sw);
    check("t4_sc2_dload", ld, 32'd0);
    check("t4_sc2_wen", 32'(sw), 32'd0);
    check("t4_sc2_cycles", 32'(cyc), 32'd1);
    d_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, cyc, ld, sw);
    check("t4_readback", ld, 32'h0000DEAD);

    // 5: store to the linked word kills the link; store elsewhere does not
    d_txn(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, cyc, ld, sw);
    d_txn(1'b0, 1'b1, 1'b0, 32'h80, 32'h1111, cyc, ld, sw);
    d_txn(1'b0, 1'b1, 1'b1, 32'h80, 32'h2222, cyc, ld, sw);
    check("t5_sc_killed_dload", ld, 32'd0);
    check("t5_sc_killed_wen", 32'(sw), 32'd0);
    d_txn(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, cyc, ld, sw);
    check("t5_ll2_data", ld, 32'h00001111);
    d_txn(1'b0, 1'b1, 1'b0, 32'h84, 32'h3333, cyc, ld, sw);
    d_txn(1'b0, 1'b1, 1'b1, 32'h80, 32'h4444, cyc, ld, sw);
    check("t5_sc_pass_dload", ld, 32'd1);
    check("t5_sc_pass_wen", 32'(sw), 32'd1);
    d_txn(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, cyc, ld, sw);
    check("t5_readback", ld, 32'h00004444);

    // 7: RAM latency of two BUSY cycles
    ram_lat = 2;
    d_txn(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, cyc, ld, sw);
    check("t7_lat_cycles", 32'(cyc), 32'd4);
    check("t7_lat_data", ld, 32'hC0DE0104);
    ram_lat = 0;

    // 6: reset during a BUSY data access, then an ERROR completion
    d_txn(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, cyc, ld, sw);
    ram_lat = 100;
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h200;
    @(negedge CLK);
    @(negedge CLK);
    check("t6_busy_ramREN", 32'(ramREN), 32'd1);
    check("t6_busy_dwait", 32'(dwait), 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b0; dREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("t6_after_rst_ramREN", 32'(ramREN), 32'd0);
    check("t6_after_rst_ramWEN", 32'(ramWEN), 32'd0);
    ram_lat = 0;
    d_txn(1'b0, 1'b1, 1'b1, 32'h40, 32'h7777, cyc, ld, sw);
    check("t6_link_cleared_dload", ld, 32'd0);
    check("t6_link_cleared_cycles", 32'(cyc), 32'd1);
    check("t6_link_cleared_wen", 32'(sw), 32'd0);

    force_error = 1'b1;
    d_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, cyc, ld, sw);
    force_error = 1'b0;
    check("t6_err_data", ld, 32'hC0DE0100);
    check("t6_err_cycles", 32'(cyc), 32'd2);
    d_txn(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, cyc, ld, sw);
    @(negedge CLK);
    check("t6_memerr_sticky", 32'(memerr), 32'd1);
    pulse_reset();
    @(negedge CLK);
    check("t6_memerr_cleared", 32'(memerr), 32'd0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
